// File: rtl/mem_port_arbiter_pkg.sv
// Shared CPU package: arbiter state encoding, port ids and watchdog default.
package mem_port_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam logic PORT_IF  = 1'b0;
    localparam logic PORT_MEM = 1'b1;

    localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: contention goes to the port that was not served last.
module mem_port_arbiter_rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner,
    output logic any
);

    // Winner selection; a lone requester wins regardless of last.
    always_comb begin
        any = req0 | req1;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = PORT_MEM;
        end else begin
            winner = PORT_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter between fetch (port 0) and data (port 1) with a
// req/ready handshake, round-robin fairness and a watchdog abort.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CW      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic we1,
    input  logic mem_ready,
    output logic sel,
    output logic mem_req,
    output logic mem_we,
    output logic ack0,
    output logic ack1,
    output logic err,
    output logic busy
);

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    arb_state_e    state_q, state_d;
    logic          sel_q, sel_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic          err_q, err_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          winner_s;
    logic          any_s;

    mem_port_arbiter_rr_pick2 u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last_q),
        .winner (winner_s),
        .any    (any_s)
    );

    // Next-state logic: grant in IDLE, complete or abort in BUSY.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        mem_req_d = mem_req_q;
        mem_we_d  = mem_we_q;
        err_d     = 1'b0;
        last_d    = last_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_s) begin
                    sel_d     = winner_s;
                    mem_req_d = 1'b1;
                    mem_we_d  = winner_s & we1;
                    cnt_d     = {CW{1'b0}};
                    state_d   = ST_BUSY;
                end else begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            ST_BUSY: begin
                // Ready takes priority over a coincident watchdog expiry.
                if (mem_ready) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    last_d    = sel_q;
                end else if (cnt_q == CNT_LAST) begin
                    err_d     = 1'b1;
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    last_d    = sel_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; last resets to 1 so fetch wins first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= PORT_IF;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            err_q     <= 1'b0;
            last_q    <= PORT_MEM;
            cnt_q     <= {CW{1'b0}};
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            err_q     <= err_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy    = (state_q == ST_BUSY);
    assign sel     = sel_q;
    assign mem_req = mem_req_q;
    assign mem_we  = mem_we_q;
    assign err     = err_q;
    assign ack0    = busy & mem_ready & ~sel_q;
    assign ack1    = busy & mem_ready & sel_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (watchdog TIMEOUT=4).
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n, req0, req1, we1, mem_ready;
    logic sel, mem_req, mem_we, ack0, ack1, err, busy;
    int   total = 0;
    int   bad   = 0;
    int   acks  = 0;
    logic exp_sel;

    mem_port_arbiter #(.TIMEOUT(4), .CW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .we1       (we1),
        .mem_ready (mem_ready),
        .sel       (sel),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .ack0      (ack0),
        .ack1      (ack1),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    // Output vector order: {sel, mem_req, mem_we, ack0, ack1, err, busy}
    task automatic chk(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        #1;
        obs = {sel, mem_req, mem_we, ack0, ack1, err, busy};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; mem_ready = 1'b0;
        #12;
        chk("reset_state", 7'b0000000);
        #5 rst_n = 1'b1;
        nxt();
        chk("reset_first_grant", 7'b0100001);
        mem_ready = 1'b1;
        chk("reset_grant_ack0", 7'b0101001);
        nxt();
        req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0;
        chk("after_ack_idle", 7'b0000000);

        // single fetch, ready in the second BUSY cycle
        req0 = 1'b1;
        nxt();
        chk("fetch_grant", 7'b0100001);
        nxt();
        mem_ready = 1'b1;
        chk("fetch_ack0", 7'b0101001);
        nxt();
        req0 = 1'b0; mem_ready = 1'b0;
        chk("fetch_done", 7'b0000000);

        // mem_ready while idle is ignored
        mem_ready = 1'b1;
        chk("idle_ready_0", 7'b0000000);
        nxt();
        chk("idle_ready_1", 7'b0000000);
        mem_ready = 1'b0;

        // write with we1 and req0 changing mid-BUSY
        req1 = 1'b1; we1 = 1'b1;
        nxt();
        chk("write_grant", 7'b1110001);
        we1 = 1'b0;
        nxt();
        chk("write_we_hold", 7'b1110001);
        req0 = 1'b1;
        nxt();
        chk("write_req0_ignored", 7'b1110001);
        mem_ready = 1'b1;
        chk("write_ack1", 7'b1110101);
        nxt();
        req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0;
        chk("write_done", 7'b1000000);

        // continuous contention: 4 transactions of 4 cycles each
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_sel = i[0];
            nxt();
            chk($sformatf("rr_grant_%0d", i), {exp_sel, 6'b100001});
            nxt();
            nxt();
            mem_ready = 1'b1;
            chk($sformatf("rr_ack_%0d", i), {exp_sel, 2'b10, ~exp_sel, exp_sel, 2'b01});
            if (ack0 || ack1) acks++;
            nxt();
            mem_ready = 1'b0;
            chk($sformatf("rr_idle_%0d", i), {exp_sel, 6'b000000});
        end
        total++;
        assert (acks == 4) else begin
            bad++;
            $error("FAIL rr_ack_count observed=%0d expected=%0d", acks, 4);
        end
        req0 = 1'b0; req1 = 1'b0;

        // watchdog abort of a data read that never completes
        req1 = 1'b1;
        nxt();
        chk("to_grant", 7'b1100001);
        nxt();
        chk("to_busy1", 7'b1100001);
        nxt();
        chk("to_busy2", 7'b1100001);
        nxt();
        chk("to_busy3", 7'b1100001);
        nxt();
        chk("to_err", 7'b1000010);
        req0 = 1'b1;
        nxt();
        req1 = 1'b0;
        chk("to_next_grant_p0", 7'b0100001);

        // ready in the final watchdog cycle wins over the abort
        nxt();
        nxt();
        nxt();
        mem_ready = 1'b1;
        chk("ready_at_timeout_ack", 7'b0101001);
        nxt();
        req0 = 1'b0; mem_ready = 1'b0;
        chk("ready_at_timeout_no_err", 7'b0000000);

        // asynchronous reset in the middle of a transaction
        req1 = 1'b1;
        nxt();
        chk("rst_busy_grant", 7'b1100001);
        rst_n = 1'b0; mem_ready = 1'b1;
        chk("rst_busy_drop", 7'b0000000);
        req1 = 1'b0;
        #2 rst_n = 1'b1;
        nxt();
        chk("rst_busy_after", 7'b0000000);
        mem_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
